// File: rtl/uart_tx.sv
// UART transmitter: pulls bytes from an upstream registered-read FIFO and serialises 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: READ + LATCH (2 cycles) before the start bit; each bit lasts CLKS_PER_BIT cycles; 42 busy cycles per frame at CLKS_PER_BIT=4.
// Backpressure: reads only when fifo_empty is low, in IDLE or on stop-bit exit; one fifo_rd_en pulse per frame.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

    // Last count of a bit period, and the count one before it (tx_done is
    // registered, so it has to be raised one cycle ahead of the final cycle).
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DONE_AT   = 16'(CLKS_PER_BIT - 2);

    state_t      state_q;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic        tx_q;
    logic        rd_en_q;
    logic        busy_q;
    logic        done_q;
    logic        baud_last;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    // Baud counter next value: wraps at the end of every bit period, which is
    // exactly where the timed states change, so it also clears on state change.
    assign baud_last = (baud_q == BAUD_LAST);
    assign baud_d    = baud_last ? 16'd0 : baud_q + 16'd1;

    // Frame sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= 16'd0;
                    tx_q   <= 1'b1;
                    if (!fifo_empty) begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    baud_q  <= 16'd0;
                    state_q <= LATCH;
                end
                LATCH: begin
                    // Registered FIFO data is valid here, one cycle after the read.
                    baud_q   <= 16'd0;
                    shreg_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^fifo_data;
`endif
                    tx_q     <= 1'b0;
                    state_q  <= START;
                end
                START: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q   <= DATA;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shreg_q[0];
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        // Index wraps 7 -> 0 naturally on the final data bit.
                        bit_idx_q <= bit_idx_q + 3'd1;
                        shreg_q   <= shreg_q >> 1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shreg_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    baud_q <= baud_d;
                    if (baud_last) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    baud_q <= baud_d;
                    tx_q   <= 1'b1;
                    if (baud_q == DONE_AT) begin
                        done_q <= 1'b1;
                    end
                    if (baud_last) begin
                        if (!fifo_empty) begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    baud_q  <= 16'd0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4 with a registered-read FIFO model.
// Latency: outputs sampled on the falling edge, one record per cycle.
// Backpressure: fifo_empty comes from the model, optionally overridden by a toggle pattern.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int BUSY_CYC = NB * CPB + 2;
    localparam int TMAX     = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Upstream FIFO model: registered read data, pointer-based empty flag.
    logic [7:0] mem [256];
    logic [7:0] wr_ptr  = 8'd0;
    logic [7:0] rd_ptr  = 8'd0;
    logic       tog_en  = 1'b0;
    logic       tog_val = 1'b0;

    assign fifo_empty = tog_en ? tog_val : (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    typedef struct {
        logic [7:0]  dat;
        logic [10:0] f10;   // bit k = k-th serial bit: start, d0..d7, stop
        logic [10:0] f11;   // bit k = k-th serial bit: start, d0..d7, parity, stop
    } vec_t;

    vec_t vt [9];

    logic t_tx   [TMAX];
    logic t_busy [TMAX];
    logic t_rd   [TMAX];
    logic t_done [TMAX];
    int   tn = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Record ncyc falling-edge samples; toggle fifo_empty in [tog_lo, tog_hi).
    task automatic capture(input int ncyc, input int tog_lo, input int tog_hi);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            t_tx[i]   = tx;
            t_busy[i] = busy;
            t_rd[i]   = fifo_rd_en;
            t_done[i] = tx_done;
            if (i >= tog_lo && i < tog_hi) begin
                tog_en  = 1'b1;
                tog_val = ~tog_val;
            end else begin
                tog_en = 1'b0;
            end
        end
        tog_en = 1'b0;
        tn = ncyc;
    endtask

    function automatic int cnt_rd();
        int c = 0;
        for (int i = 0; i < tn; i++) if (t_rd[i]) c++;
        return c;
    endfunction

    function automatic int cnt_busy();
        int c = 0;
        for (int i = 0; i < tn; i++) if (t_busy[i]) c++;
        return c;
    endfunction

    function automatic int cnt_done();
        int c = 0;
        for (int i = 0; i < tn; i++) if (t_done[i]) c++;
        return c;
    endfunction

    function automatic int nth_rd(input int n);
        int c = 0;
        for (int i = 0; i < tn; i++) begin
            if (t_rd[i]) begin
                c++;
                if (c == n) return i;
            end
        end
        return -1;
    endfunction

    function automatic int find_low(input int from);
        for (int i = from; i < tn; i++) if (!t_tx[i]) return i;
        return -1;
    endfunction

    function automatic logic [10:0] fexp(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return v.f11;
`else
        return v.f10;
`endif
    endfunction

    // Each serial bit must hold its value for all CPB samples.
    task automatic check_frame(input string nm, input int s, input logic [10:0] bits);
        if (s < 0 || s + NB * CPB > tn) begin
            chk({nm, " frame_in_window"}, s, 0);
        end else begin
            for (int k = 0; k < NB; k++) begin
                int act = 0;
                for (int j = 0; j < CPB; j++) begin
                    if (t_tx[s + k * CPB + j]) act = act | (1 << j);
                end
                chk($sformatf("%s bit%0d", nm, k), act, bits[k] ? 15 : 0);
            end
        end
    endtask

    task automatic check_single(input vec_t v);
        string nm;
        int    s;
        nm = $sformatf("byte_%02h", v.dat);
        push(v.dat);
        capture(BUSY_CYC + 4, -1, -1);
        chk({nm, " rd_pulses"}, cnt_rd(), 1);
        chk({nm, " rd_index"}, nth_rd(1), 0);
        s = find_low(0);
        chk({nm, " start_index"}, s, 2);
        check_frame(nm, s, fexp(v));
        chk({nm, " busy_cycles"}, cnt_busy(), BUSY_CYC);
        chk({nm, " done_pulses"}, cnt_done(), 1);
        chk({nm, " done_last_busy"}, int'(t_done[BUSY_CYC - 1]), 1);
        chk({nm, " idle_after"}, int'({t_tx[tn - 1], t_busy[tn - 1]}), 2);
    endtask

    initial begin
        int s1;
        int s2;

        vt[0] = '{dat: 8'h55, f10: 11'b0_1_01010101_0, f11: 11'b1_0_01010101_0};
        vt[1] = '{dat: 8'h00, f10: 11'b0_1_00000000_0, f11: 11'b1_0_00000000_0};
        vt[2] = '{dat: 8'hFF, f10: 11'b0_1_11111111_0, f11: 11'b1_0_11111111_0};
        vt[3] = '{dat: 8'h80, f10: 11'b0_1_10000000_0, f11: 11'b1_1_10000000_0};
        vt[4] = '{dat: 8'h07, f10: 11'b0_1_00000111_0, f11: 11'b1_1_00000111_0};
        vt[5] = '{dat: 8'h03, f10: 11'b0_1_00000011_0, f11: 11'b1_0_00000011_0};
        vt[6] = '{dat: 8'hA5, f10: 11'b0_1_10100101_0, f11: 11'b1_0_10100101_0};
        vt[7] = '{dat: 8'h3C, f10: 11'b0_1_00111100_0, f11: 11'b1_0_00111100_0};
        vt[8] = '{dat: 8'h96, f10: 11'b0_1_10010110_0, f11: 11'b1_0_10010110_0};

        // Reset held with data available: outputs pinned to idle values.
        rst_n = 1'b0;
        push(8'h55);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("reset_hold cyc%0d {tx,rd,busy,done}", i),
                int'({tx, fifo_rd_en, busy, tx_done}), 8);
        end
        wr_ptr = rd_ptr;
        rst_n  = 1'b1;

        // Empty FIFO: stays in IDLE.
        capture(4, -1, -1);
        chk("idle_empty busy_cycles", cnt_busy(), 0);
        chk("idle_empty rd_pulses", cnt_rd(), 0);
        chk("idle_empty tx_high", int'(t_tx[3]), 1);

        // Single frames from the vector table.
        for (int v = 0; v < 6; v++) begin
            check_single(vt[v]);
        end

        // Back-to-back 0xA5 then 0x3C.
        push(vt[6].dat);
        push(vt[7].dat);
        capture(2 * BUSY_CYC + 4, -1, -1);
        chk("b2b rd_pulses", cnt_rd(), 2);
        chk("b2b rd_spacing", nth_rd(2) - nth_rd(1), BUSY_CYC);
        s1 = find_low(0);
        chk("b2b start1_index", s1, 2);
        check_frame("b2b frame1", s1, fexp(vt[6]));
        s2 = (s1 < 0) ? -1 : find_low(s1 + NB * CPB);
        chk("b2b gap_cycles", (s2 < 0) ? -1 : s2 - (s1 + NB * CPB), 2);
        check_frame("b2b frame2", s2, fexp(vt[7]));
        chk("b2b busy_cycles", cnt_busy(), 2 * BUSY_CYC);
        chk("b2b done_pulses", cnt_done(), 2);

        // fifo_empty toggling through DATA must not cause reads or corrupt the byte.
        push(vt[8].dat);
        capture(BUSY_CYC + 4, 6, 36);
        chk("toggle rd_pulses", cnt_rd(), 1);
        check_frame("toggle frame", find_low(0), fexp(vt[8]));
        chk("toggle done_pulses", cnt_done(), 1);

        // Reset during data bit 3 of 0xF0, next byte 0x3C already queued.
        push(8'hF0);
        push(vt[7].dat);
        capture(20, -1, -1);
        chk("midrst rd_before", cnt_rd(), 1);
        chk("midrst tx_bit3_low", int'(t_tx[19]), 0);
        chk("midrst done_before", cnt_done(), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst async {tx,rd,busy,done}", int'({tx, fifo_rd_en, busy, tx_done}), 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst hold cyc%0d {tx,rd,busy,done}", i),
                int'({tx, fifo_rd_en, busy, tx_done}), 8);
        end
        rst_n = 1'b1;
        capture(BUSY_CYC + 4, -1, -1);
        chk("midrst resume rd_index", nth_rd(1), 0);
        chk("midrst resume rd_pulses", cnt_rd(), 1);
        chk("midrst resume start_index", find_low(0), 2);
        check_frame("midrst resume", find_low(0), fexp(vt[7]));
        chk("midrst resume done_pulses", cnt_done(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
